pc_gen: RTL
===========

// Module: pc_gen
// PURPOSE
//  Parametrised fetch-PC generator for the IF stage. Holds the word-aligned fetch PC,
//  selects next PC by fixed priority (exception > redirect > stall > sequential), adds
//  boot/run/halt sequencing and a fetch-valid qualifier. Drives the I-mem address.
// PARAMETERS
//  ADDR_W     32             byte-address width; PC carries bits [ADDR_W-1:2]
//  START_ADDR 32'h0000_3000  byte reset vector (word 30'h0000C00); low 2 bits ignored
//  EXC_ADDR   32'h0000_4180  byte exception vector; low 2 bits ignored
//  RAS_DEPTH  4              return-address-stack entries (only with PC_RAS_EN), power of 2 >= 2
// PORTS
//  clk          in   1         rising-edge clock
//  reset        in   1         synchronous, active-low reset
//  PCWrite      in   1         1 = advance/load PC this cycle; 0 = stall (hold)
//  redirect     in   1         branch/jump resolved taken
//  redirect_pc  in   ADDR_W-2  redirect target, word address
//  exc          in   1         exception/interrupt request
//  halt         in   1         request halt of fetch
//  call         in   1         fetched insn is a call (PC_RAS_EN only; ignored otherwise)
//  ret          in   1         fetched insn is a return (PC_RAS_EN only; ignored otherwise)
//  PC           out  ADDR_W-2  current fetch word address, [ADDR_W-1:2]
//  pc_valid     out  1         PC is a real fetch this cycle
//  halted       out  1         state == HALT
//  wrap_err     out  1         sticky: sequential increment wrapped to 0
// BEHAVIOUR
//  - All state updates on posedge clk. reset==0 at an edge: PC<=START_ADDR[ADDR_W-1:2],
//    state<=BOOT, pc_valid=0, halted=0, wrap_err<=0, RAS emptied; dominates every input.
//  - States: BOOT -> RUN unconditionally after one cycle (PC unchanged, pc_valid=0).
//    RUN: pc_valid=1. RUN -> HALT when halt=1 (PC holds). HALT: pc_valid=0, halted=1;
//    HALT -> RUN on exc (PC<=EXC) or redirect (PC<=redirect_pc); halt ignored in HALT.
//  - Next PC in RUN, first match wins:
//    1 exc=1          -> EXC_ADDR word; ignores PCWrite; RAS emptied
//    2 redirect=1     -> redirect_pc; ignores PCWrite
//    3 PCWrite=0      -> hold (call/ret/halt also ignored this cycle)
//    4 halt=1         -> hold, enter HALT
//    5 ret=1, RAS non-empty (PC_RAS_EN) -> top of RAS, pop
//    6 otherwise      -> PC+1 (word), modulo 2^(ADDR_W-2)
//  - Wrap: PC all-ones with case 6 -> PC<=0 and wrap_err<=1 (held until reset).
//  - Latency: target visible on PC the cycle after the selecting edge; no bypass.
//  - exc/redirect in BOOT are ignored; BOOT always completes.
// CONFIGURATION
//  PC_RAS_EN defined: circular RAS of RAS_DEPTH x (ADDR_W-2). On a RUN cycle reaching
//   case 5/6 with call=1: push PC+1. ret=1 with call=1: top replaced by PC+1, next PC is
//   the old top (pop+push). Push when full overwrites oldest. ret on empty -> case 6,
//   no underflow state change. redirect does not touch RAS; exc empties it.
//  PC_RAS_EN undefined: no RAS storage; call/ret unused; case 5 never taken.
// STRUCTURE
//  - Shared pkg/header pc_pkg: state encoding (PCS_BOOT=2'd0, PCS_RUN=2'd1,
//    PCS_HALT=2'd2), default START/EXC vector constants.
//  - One sub-module: pc_ras (pointer/count + array, push/pop/clear ports), instantiated
//    only under `ifdef PC_RAS_EN. Next-PC mux and FSM stay in pc_gen.
// TESTING
//  1 reset=0 two cycles, release -> PC=30'h0000C00, pc_valid 0 for 1 cycle, then 1; PC
//    increments C01, C02...
//  2 PCWrite=0 for 3 cycles in RUN -> PC frozen; redirect=1 pc=30'h100 while
//    PCWrite=0 -> PC=100 next cycle.
//  3 exc=1 and redirect=1 same cycle -> PC=EXC word 30'h1060; redirect dropped.
//  4 halt=1 at PC=C05 -> halted=1, pc_valid=0, PC stays C05; redirect to 200 -> RUN, PC=200.
//  5 force PC=30'h3FFFFFFF via redirect, then run -> PC=0, wrap_err=1 until reset;
//    assert reset=0 mid-run -> all outputs back to reset values next edge.
//  6 PC_RAS_EN: call at 10,20,30,40,50 (depth 4) then 5 rets -> targets 51,41,31,21,
//    then sequential (empty); call+ret same cycle -> pops old top, pushes PC+1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-PC generator: sequencing state encoding and default vectors.
package pc_pkg;

  typedef enum logic [1:0] {
    PCS_BOOT = 2'd0,
    PCS_RUN  = 2'd1,
    PCS_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_DEF_START_ADDR = 32'h0000_3000;
  localparam logic [31:0] PC_DEF_EXC_ADDR   = 32'h0000_4180;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full, clear empties it.
module pc_ras #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] ptr_q, ptr_d, wr_idx_s;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             wr_en_s;
  logic [W-1:0]     mem_q [DEPTH];

  // pointer/count update; simultaneous push+pop rewrites the top slot in place
  always_comb begin
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    wr_idx_s = ptr_q;
    if (clear) begin
      cnt_d = {(PTR_W+1){1'b0}};
    end else if (push && pop) begin
      wr_en_s = 1'b1;
    end else if (push) begin
      ptr_d    = ptr_q + PTR_W'(1'b1);
      wr_idx_s = ptr_q + PTR_W'(1'b1);
      wr_en_s  = 1'b1;
      if (cnt_q != DEPTH_C) begin
        cnt_d = cnt_q + (PTR_W+1)'(1'b1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop) begin
      ptr_d = ptr_q - PTR_W'(1'b1);
      cnt_d = cnt_q - (PTR_W+1)'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // control state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {(PTR_W+1){1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // entry storage carries no reset; count alone defines validity
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= push_data;
    end
  end

  assign top   = mem_q[ptr_q];
  assign empty = (cnt_q == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: priority next-PC select with BOOT/RUN/HALT sequencing.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(PC_DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] EXC_ADDR   = ADDR_W'(PC_DEF_EXC_ADDR),
  parameter int              RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWrite,
  input  logic              redirect,
  input  logic [ADDR_W-3:0] redirect_pc,
  input  logic              exc,
  input  logic              halt,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-3:0] PC,
  output logic              pc_valid,
  output logic              halted,
  output logic              wrap_err
);

  localparam int PC_W = ADDR_W - 2;
  localparam logic [PC_W-1:0] START_PC = START_ADDR[ADDR_W-1:2];
  localparam logic [PC_W-1:0] EXC_PC   = EXC_ADDR[ADDR_W-1:2];

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc_s, ras_top_s;
  logic            valid_q, valid_d, halted_q, halted_d, wrap_q, wrap_d;
  logic            ras_push_s, ras_pop_s, ras_clear_s, ras_empty_s;

  assign pc_inc_s = pc_q + PC_W'(1'b1);

`ifdef PC_RAS_EN
  pc_ras #(
    .W    (PC_W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push_s),
    .pop      (ras_pop_s),
    .clear    (ras_clear_s),
    .push_data(pc_inc_s),
    .top      (ras_top_s),
    .empty    (ras_empty_s)
  );
`else
  logic unused_ras_s;
  assign ras_empty_s  = 1'b1;
  assign ras_top_s    = {PC_W{1'b0}};
  assign unused_ras_s = ras_push_s ^ ras_pop_s ^ ras_clear_s;
`endif

  // next-state / next-PC selection
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wrap_d      = wrap_q;
    ras_push_s  = 1'b0;
    ras_pop_s   = 1'b0;
    ras_clear_s = 1'b0;
    case (state_q)
      PCS_BOOT: begin
        state_d = PCS_RUN;
      end
      PCS_RUN: begin
        if (exc) begin
          pc_d        = EXC_PC;
          ras_clear_s = 1'b1;
        end else if (redirect) begin
          pc_d = redirect_pc;
        end else if (!PCWrite) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d = PCS_HALT;
        end else begin
          ras_push_s = call;
          if (ret && !ras_empty_s) begin
            pc_d      = ras_top_s;
            ras_pop_s = 1'b1;
          end else begin
            pc_d = pc_inc_s;
            if (pc_q == {PC_W{1'b1}}) begin
              wrap_d = 1'b1;
            end else begin
              wrap_d = wrap_q;
            end
          end
        end
      end
      PCS_HALT: begin
        if (exc) begin
          pc_d        = EXC_PC;
          ras_clear_s = 1'b1;
          state_d     = PCS_RUN;
        end else if (redirect) begin
          pc_d    = redirect_pc;
          state_d = PCS_RUN;
        end else begin
          state_d = PCS_HALT;
        end
      end
      default: begin
        state_d = PCS_BOOT;
      end
    endcase
    valid_d  = (state_d == PCS_RUN);
    halted_d = (state_d == PCS_HALT);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= PCS_BOOT;
      pc_q     <= START_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      wrap_q   <= wrap_d;
    end
  end

  assign PC       = pc_q;
  assign pc_valid = valid_q;
  assign halted   = halted_q;
  assign wrap_err = wrap_q;

endmodule
